// File: rtl/input_port_route_buffer.sv
// Input-port flit FIFO with XY route computation and wormhole route locking.
// The head flit requests an output port from the switch allocator; a grant
// pops it and returns one credit upstream on the following cycle.
module input_port_route_buffer #(
  parameter int FLIT_W = 32,
  parameter int DEPTH  = 4,
  parameter int CUR_X  = 0,
  parameter int CUR_Y  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [FLIT_W-1:0] flit_in,
  input  logic              flit_in_valid,
  input  logic              sw_grant,
  output logic [FLIT_W-1:0] flit_out,
  output logic [2:0]        dst,
  output logic              dst_valid,
  output logic              credit_out,
  output logic              overflow_err
);

  // Global output-port codes shared with the switch allocator.
  localparam logic [2:0] OUT_LOCAL_PORT = 3'd0;
  localparam logic [2:0] OUT_X1_PORT    = 3'd1;
  localparam logic [2:0] OUT_X2_PORT    = 3'd2;
  localparam logic [2:0] OUT_Y1_PORT    = 3'd3;

  localparam logic [1:0] T_BODY      = 2'b00;
  localparam logic [1:0] T_HEAD      = 2'b01;
  localparam logic [1:0] T_TAIL      = 2'b10;
  localparam logic [1:0] T_HEAD_TAIL = 2'b11;

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic {IDLE, ROUTED} state_t;

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              empty, full, pop, push;
  logic [FLIT_W-1:0] head;
  logic [1:0]        head_type;
  logic [1:0]        dest_x;
  logic              dest_y;
  logic [2:0]        xy_route, cur_route, route_q, route_d;
  state_t            state_q, state_d;
  logic              credit_q, overflow_q;

  assign empty     = (count == '0);
  assign full      = (count == CNT_FULL);
  assign pop       = en & ~empty & sw_grant;
  // A write into a full FIFO only lands if the head leaves on the same edge.
  assign push      = flit_in_valid & (~full | pop);

  assign head      = mem[rd_ptr];
  assign head_type = head[FLIT_W-1 -: 2];
  assign dest_x    = head[FLIT_W-3 -: 2];
  assign dest_y    = head[FLIT_W-5];

  // Storage array; contents are only meaningful when count covers the slot.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= flit_in;
  end

  // Pointers, occupancy, credit pulse and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      credit_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      credit_q <= pop;
      if (flit_in_valid && full && !pop) overflow_q <= 1'b1;
    end
  end

  // Dimension-ordered route: resolve X first, then Y, else eject locally.
  always_comb begin
    xy_route = OUT_LOCAL_PORT;
    if (int'(dest_x) < CUR_X)       xy_route = OUT_X1_PORT;
    else if (int'(dest_x) > CUR_X)  xy_route = OUT_X2_PORT;
    else if (int'(dest_y) != CUR_Y) xy_route = OUT_Y1_PORT;
  end

  // Wormhole state and locked route register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      route_q <= OUT_LOCAL_PORT;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
    end
  end

  // Next state, route latch and outputs. A malformed head (body/tail while
  // idle) is forwarded on whatever route is currently locked.
  always_comb begin
    state_d   = state_q;
    route_d   = route_q;
    cur_route = route_q;
    if (state_q == IDLE && (head_type == T_HEAD || head_type == T_HEAD_TAIL))
      cur_route = xy_route;
    if (pop) begin
      case (state_q)
        IDLE: begin
          if (head_type == T_HEAD) begin
            state_d = ROUTED;
            route_d = cur_route;
          end
        end
        ROUTED: begin
          if (head_type == T_TAIL || head_type == T_HEAD_TAIL) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    dst = cur_route;
    if (state_q == IDLE && empty) dst = OUT_LOCAL_PORT;
  end

  assign dst_valid    = ~empty;
  assign flit_out     = empty ? '0 : head;
  assign credit_out   = credit_q;
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_input_port_route_buffer.sv
// Directed bench for input_port_route_buffer at router (1,0), 4-entry FIFO.
module tb_input_port_route_buffer;

  localparam logic [2:0] LOC = 3'd0;
  localparam logic [2:0] X1  = 3'd1;
  localparam logic [2:0] X2  = 3'd2;
  localparam logic [2:0] Y1  = 3'd3;

  localparam logic [1:0] TB  = 2'b00;
  localparam logic [1:0] TH  = 2'b01;
  localparam logic [1:0] TT  = 2'b10;
  localparam logic [1:0] THT = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [31:0] flit_in;
  logic        flit_in_valid;
  logic        sw_grant;
  logic [31:0] flit_out;
  logic [2:0]  dst;
  logic        dst_valid;
  logic        credit_out;
  logic        overflow_err;

  int errors = 0;
  int checks = 0;

  input_port_route_buffer #(.FLIT_W(32), .DEPTH(4), .CUR_X(1), .CUR_Y(0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flit_in(flit_in),
    .flit_in_valid(flit_in_valid), .sw_grant(sw_grant), .flit_out(flit_out),
    .dst(dst), .dst_valid(dst_valid), .credit_out(credit_out),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] fin;
    logic        v, g, e;
    logic        edv;
    logic [2:0]  edst;
    logic        ecr, eovf;
    logic [31:0] efo;
  } vec_t;

  vec_t vecs[32];
  int   nv = 0;

  function automatic logic [31:0] mk(input logic [1:0] t, input logic [1:0] x,
                                     input logic y, input logic [26:0] p);
    return {t, x, y, p};
  endfunction

  task automatic add(input logic [31:0] fin, input logic v, input logic g,
                     input logic e, input logic edv, input logic [2:0] edst,
                     input logic ecr, input logic [31:0] efo);
    vecs[nv].fin  = fin;
    vecs[nv].v    = v;
    vecs[nv].g    = g;
    vecs[nv].e    = e;
    vecs[nv].edv  = edv;
    vecs[nv].edst = edst;
    vecs[nv].ecr  = ecr;
    vecs[nv].eovf = 1'b0;
    vecs[nv].efo  = efo;
    nv++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flit_in       = '0;
    flit_in_valid = 1'b0;
    sw_grant      = 1'b0;
    en            = 1'b1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  logic [31:0] ht30, h11, b1, b2, t1, h00, t2, h10;
  logic [31:0] f[5];

  initial begin
    ht30 = mk(THT, 2'd3, 1'b0, 27'h0000a1);
    h11  = mk(TH,  2'd1, 1'b1, 27'h0000b1);
    b1   = mk(TB,  2'd0, 1'b0, 27'h0000b2);
    b2   = mk(TB,  2'd0, 1'b0, 27'h0000b3);
    t1   = mk(TT,  2'd0, 1'b0, 27'h0000b4);
    h00  = mk(TH,  2'd0, 1'b0, 27'h0000c1);
    t2   = mk(TT,  2'd0, 1'b0, 27'h0000c2);
    h10  = mk(TH,  2'd1, 1'b0, 27'h0000d1);
    for (int k = 0; k < 5; k++) f[k] = mk(THT, 2'(k), 1'b0, 27'(32'h100 + k));

    // HEAD_TAIL to x=3: eastbound, single grant, single credit.
    add(ht30, 1, 0, 1, 1, X2,  0, ht30);
    add('0,   0, 1, 1, 0, LOC, 1, '0);
    add('0,   0, 0, 1, 0, LOC, 0, '0);
    // Four-flit packet to (1,1): northbound, grant every other cycle.
    add(h11,  1, 0, 1, 1, Y1,  0, h11);
    add(b1,   1, 0, 1, 1, Y1,  0, h11);
    add(b2,   1, 1, 1, 1, Y1,  1, b1);
    add(t1,   1, 0, 1, 1, Y1,  0, b1);
    add('0,   0, 1, 1, 1, Y1,  1, b2);
    add('0,   0, 0, 1, 1, Y1,  0, b2);
    add('0,   0, 1, 1, 1, Y1,  1, t1);
    add('0,   0, 0, 1, 1, Y1,  0, t1);
    add('0,   0, 1, 1, 0, LOC, 1, '0);
    // Back in IDLE: a fresh head is routed by XY, not the old locked route.
    add(ht30, 1, 0, 1, 1, X2,  0, ht30);
    add('0,   0, 1, 1, 0, LOC, 1, '0);
    // Westbound head held while en=0; a write during en=0 still lands.
    add(h00,  1, 0, 1, 1, X1,  0, h00);
    add('0,   0, 1, 0, 1, X1,  0, h00);
    add(t2,   1, 1, 0, 1, X1,  0, h00);
    add('0,   0, 1, 0, 1, X1,  0, h00);
    add('0,   0, 1, 1, 1, X1,  1, t2);
    add('0,   0, 1, 1, 0, LOC, 1, '0);
    add('0,   0, 0, 1, 0, LOC, 0, '0);

    idle_inputs();
    rst_n = 1'b0;
    #2;
    chk("rst_dst_valid", 32'(dst_valid), 0);
    chk("rst_credit", 32'(credit_out), 0);
    chk("rst_overflow", 32'(overflow_err), 0);
    chk("rst_flit_out", flit_out, 0);
    chk("rst_dst", 32'(dst), 32'(LOC));
    @(negedge clk);
    rst_n = 1'b1;

    for (int c = 0; c < 10; c++) begin
      cyc();
      chk("idle_dst_valid", 32'(dst_valid), 0);
      chk("idle_credit", 32'(credit_out), 0);
      chk("idle_overflow", 32'(overflow_err), 0);
    end

    for (int i = 0; i < nv; i++) begin
      flit_in       = vecs[i].fin;
      flit_in_valid = vecs[i].v;
      sw_grant      = vecs[i].g;
      en            = vecs[i].e;
      cyc();
      chk($sformatf("vec%0d_dst_valid", i), 32'(dst_valid), 32'(vecs[i].edv));
      chk($sformatf("vec%0d_dst", i), 32'(dst), 32'(vecs[i].edst));
      chk($sformatf("vec%0d_credit", i), 32'(credit_out), 32'(vecs[i].ecr));
      chk($sformatf("vec%0d_overflow", i), 32'(overflow_err), 32'(vecs[i].eovf));
      chk($sformatf("vec%0d_flit_out", i), flit_out, vecs[i].efo);
    end
    idle_inputs();

    // Fill to full, then a fifth write with no pop is dropped and sticks the flag.
    pulse_reset();
    for (int k = 0; k < 4; k++) begin
      flit_in = f[k]; flit_in_valid = 1'b1;
      cyc();
    end
    chk("full_flit_out", flit_out, f[0]);
    chk("full_overflow", 32'(overflow_err), 0);
    flit_in = f[4];
    cyc();
    flit_in_valid = 1'b0;
    chk("ovf_set", 32'(overflow_err), 1);
    chk("ovf_head_kept", flit_out, f[0]);
    for (int k = 1; k <= 4; k++) begin
      sw_grant = 1'b1;
      cyc();
      chk("ovf_drain_flit", flit_out, (k < 4) ? f[k] : 32'h0);
      chk("ovf_sticky", 32'(overflow_err), 1);
    end
    sw_grant = 1'b0;
    cyc();
    chk("ovf_dropped_empty", 32'(dst_valid), 0);
    chk("ovf_sticky_idle", 32'(overflow_err), 1);

    // Full plus simultaneous pop: the fifth write is accepted.
    pulse_reset();
    chk("ovf_cleared", 32'(overflow_err), 0);
    for (int k = 0; k < 4; k++) begin
      flit_in = f[k]; flit_in_valid = 1'b1;
      cyc();
    end
    flit_in = f[4]; sw_grant = 1'b1;
    cyc();
    flit_in_valid = 1'b0;
    chk("pushpop_overflow", 32'(overflow_err), 0);
    chk("pushpop_flit_out", flit_out, f[1]);
    chk("pushpop_credit", 32'(credit_out), 1);
    for (int k = 2; k <= 5; k++) begin
      cyc();
      chk("pushpop_drain", flit_out, (k == 2) ? f[2] : (k == 3) ? f[3] : (k == 4) ? f[4] : 32'h0);
    end
    chk("pushpop_overflow_end", 32'(overflow_err), 0);
    sw_grant = 1'b0;
    cyc();

    // Async reset mid-packet, with a route locked and a credit pulse in flight.
    pulse_reset();
    flit_in = h11; flit_in_valid = 1'b1;
    cyc();
    flit_in = b1; sw_grant = 1'b1;
    cyc();
    flit_in_valid = 1'b0; sw_grant = 1'b0;
    chk("mid_routed_dst", 32'(dst), 32'(Y1));
    chk("mid_credit", 32'(credit_out), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_dst_valid", 32'(dst_valid), 0);
    chk("arst_credit", 32'(credit_out), 0);
    chk("arst_overflow", 32'(overflow_err), 0);
    chk("arst_flit_out", flit_out, 0);
    chk("arst_dst", 32'(dst), 32'(LOC));
    #1;
    rst_n = 1'b1;
    cyc();
    flit_in = h10; flit_in_valid = 1'b1;
    cyc();
    flit_in_valid = 1'b0;
    chk("post_rst_dst_valid", 32'(dst_valid), 1);
    chk("post_rst_dst", 32'(dst), 32'(LOC));
    chk("post_rst_flit_out", flit_out, h10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
